run_controller: RTL
===================

# run_controller

Program-sequencing controller that sits directly upstream of the processor datapath: it owns the `start`/`done` handshake with the test harness, loads the program counter with the base address of each of the three programs in turn, and gates core execution. It detects the halt instruction from the instruction-memory output and reports per-program completion. The datapath (`program_counter`, `register_file`, and the rest) advances only while `core_en` is high.

## Interface
Parameters:
- `PC_W`, 10: program-counter width.
- `PROG0_BASE`, 0: PC load value for program 0.
- `PROG1_BASE`, 256: PC load value for program 1.
- `PROG2_BASE`, 512: PC load value for program 2.
- `WDOG_CYCLES`, 65535: RUN-cycle limit; used only with the watchdog compiled in.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: harness handshake; one high-then-low pulse launches the next program.
- `instr`, in, 9: current instruction from `instruction_memory`.
- `pc_load`, out, 1: one-cycle strobe; the PC takes `pc_load_addr`.
- `pc_load_addr`, out, PC_W: base address of the program being launched.
- `core_en`, out, 1: datapath advance enable (PC and register/memory writes).
- `prog_idx`, out, 2: index of the current or last program (0..2).
- `done`, out, 1: current program has halted.
- `all_done`, out, 1: all three programs have completed.
- `timeout`, out, 1: last program was aborted by the watchdog. Tied 0 without the macro.

## Operation
- FSM states: IDLE, ARMED, LOAD, RUN, DONE, FINISHED.
- **IDLE**: waits for `start`=1, then goes to ARMED.
- **ARMED**: waits for `start`=0, then goes to LOAD.
- **LOAD**: `pc_load`=1 for one cycle, with `pc_load_addr` = base selected by `prog_idx`. Next state is RUN.
- **RUN**: `core_en`=1. When `instr` == `HALT_INSTR` (9'b010000000), go to DONE. The halt instruction itself is not executed: `core_en` drops on the next edge and the PC holds.
- **DONE**: `done`=1.
  - If `prog_idx`==2, go to FINISHED.
  - Otherwise, `start`=1 increments `prog_idx` and moves to ARMED; `done` clears on that transition.
- **FINISHED**: `done`=1 and `all_done`=1 held; `start` is ignored until reset.
- `prog_idx` increments only on the DONE→ARMED transition. It never wraps.
- In RUN, halt has priority over `start`; `start` is ignored in RUN and LOAD.
- `instr` is ignored outside RUN.

## Timing
- Reset values: state=IDLE, `prog_idx`=0, `pc_load`=0, `pc_load_addr`=0, `core_en`=0, `done`=0, `all_done`=0, `timeout`=0.
- All outputs are registered or decoded purely from state.
- Latency:
  - `start` falling edge sampled at edge N puts LOAD active in cycle N+1.
  - RUN begins at N+2; the first instruction is at the base address.
- Halt sampled at edge H: `core_en`=0 and `done`=1 from H+1.
- DONE with `start`=1 sampled at edge S: `done`=0 from S+1.
- Reset asserted mid-RUN: all outputs return immediately (asynchronously) to reset values. The next program launched is program 0.
- A `start` pulse shorter than one cycle may be missed. The harness holds `start` for at least one cycle in each level.

## Configuration
- `RUN_WATCHDOG_EN` defined: a RUN-cycle counter clears in LOAD and increments each RUN cycle.
  - Reaching `WDOG_CYCLES` forces DONE and sets `timeout`=1.
  - `timeout` stays set until the next LOAD.
  - A halt in the same cycle as expiry counts as a normal halt (`timeout`=0).
- Undefined: no counter is built, `timeout` is tied 0, and RUN is unbounded.

## Structure
- Package `run_ctrl_pkg`:
  - state enum `run_state_t`
  - `HALT_INSTR` constant
  - `NUM_PROGS`=3
  - instruction width constant `INSTR_W`=9
- Sub-module `run_watchdog` (counter plus expiry compare). It is instantiated only under `RUN_WATCHDOG_EN`.

## Test plan
- Reset, then hold `start`=1 for 2 cycles and drop it → `pc_load`=1 for exactly one cycle with `pc_load_addr`=0, and `core_en`=1 on the following cycle.
- In RUN, drive 5 non-halt instructions then 9'b010000000 → `core_en` is high for exactly 5 cycles plus the halt cycle, then `done`=1 and `core_en`=0 on the next edge.
- Run three full start/halt sequences → `pc_load_addr` is 0, 256, 512 in turn; `all_done`=1 after the third; a further `start` pulse produces no `pc_load`.
- Assert `reset` during RUN of program 1 → `core_en`=0 and `prog_idx`=0 immediately; the next start pulse loads 0.
- Assert `start`=1 and halt in the same RUN cycle → DONE is entered with `done`=1 and `prog_idx` unchanged; `done` clears only on the next `start`=1 sampled in DONE.
- With `RUN_WATCHDOG_EN` and `WDOG_CYCLES`=8, never halt → DONE after 8 RUN cycles with `timeout`=1; the next LOAD clears `timeout`.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the program-sequencing run controller.
package run_ctrl_pkg;

    localparam int unsigned INSTR_W   = 9;
    localparam int unsigned NUM_PROGS = 3;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b010000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_FINISHED
    } run_state_t;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter for the run controller; flags expiry on the
// WDOG_CYCLES-th consecutive RUN cycle.
module run_watchdog #(
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of RUN cycles already completed, so the
    // WDOG_CYCLES-th RUN cycle is the one seeing WDOG_CYCLES-1.
    assign expired = run && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/run_controller.sv
// Sequences three programs: start/done handshake, PC base load, core gating.
// Optional RUN watchdog compiled in with `define RUN_WATCHDOG_EN.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned PROG0_BASE  = 0,
    parameter int unsigned PROG1_BASE  = 256,
    parameter int unsigned PROG2_BASE  = 512,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_load_addr,
    output logic               core_en,
    output logic [1:0]         prog_idx,
    output logic               done,
    output logic               all_done,
    output logic               timeout
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

    run_state_t state, state_n;
    logic [1:0] prog_idx_n;
    logic       halt;
    logic       wdog_expired;

    assign halt = (instr == HALT_INSTR);

`ifdef RUN_WATCHDOG_EN
    run_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_LOAD),
        .run    (state == ST_RUN),
        .expired(wdog_expired)
    );

    // A halt coinciding with expiry is a normal completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (state == ST_LOAD) begin
            timeout <= 1'b0;
        end else if (state == ST_RUN && wdog_expired && !halt) begin
            timeout <= 1'b1;
        end
    end
`else
    // No watchdog: RUN is unbounded; WDOG_CYCLES is referenced only to keep
    // the parameter list identical across builds.
    assign wdog_expired = (WDOG_CYCLES == 0) && 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            prog_idx <= '0;
        end else begin
            state    <= state_n;
            prog_idx <= prog_idx_n;
        end
    end

    always_comb begin
        state_n    = state;
        prog_idx_n = prog_idx;
        unique case (state)
            ST_IDLE:     if (start) state_n = ST_ARMED;
            ST_ARMED:    if (!start) state_n = ST_LOAD;
            ST_LOAD:     state_n = ST_RUN;
            ST_RUN:      if (halt || wdog_expired) state_n = ST_DONE;
            ST_DONE: begin
                if (prog_idx == LAST_IDX) begin
                    state_n = ST_FINISHED;
                end else if (start) begin
                    state_n    = ST_ARMED;
                    prog_idx_n = prog_idx + 2'd1;
                end
            end
            ST_FINISHED: state_n = ST_FINISHED;
            default:     state_n = ST_IDLE;
        endcase
    end

    assign pc_load  = (state == ST_LOAD);
    assign core_en  = (state == ST_RUN);
    assign done     = (state == ST_DONE) || (state == ST_FINISHED);
    assign all_done = (state == ST_FINISHED);

    always_comb begin
        pc_load_addr = '0;
        if (state == ST_LOAD) begin
            unique case (prog_idx)
                2'd0:    pc_load_addr = PC_W'(PROG0_BASE);
                2'd1:    pc_load_addr = PC_W'(PROG1_BASE);
                default: pc_load_addr = PC_W'(PROG2_BASE);
            endcase
        end
    end

endmodule
